writeback_unit: RTL and testbench

- Write end of the register-file interface. Accepts completed-instruction results from execute/memory and selects ALU or memory data. Applies load-size extension by opcode.
- Buffers results in a small in-order queue and drives the register-file write port under a ready handshake.
- Provides bypass lookup so decode-side reads see pending, not-yet-committed writes.
- Sits between the memory-access stage and the register memory.

---
 rtl/writeback_unit.sv | 118 +++++++++++
 tb/tb_writeback_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: selects/extends completed results, queues them in order and drives the
// register-file write port, with bypass lookup of pending (uncommitted) writes.
module writeback_unit #(
  parameter int unsigned WORD  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [10:0]       in_opcode,
  input  logic [WORD-1:0]   in_alu_result,
  input  logic [WORD-1:0]   in_mem_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [WORD-1:0]   rf_wdata,
  input  logic              rf_ready,
  input  logic [4:0]        byp_addr1,
  input  logic [4:0]        byp_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [WORD-1:0]   byp_data1,
  output logic [WORD-1:0]   byp_data2,
  output logic              idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [10:0] OpLdurb  = 11'b00111000010;
  localparam logic [10:0] OpLdurh  = 11'b01111000010;
  localparam logic [10:0] OpLdursw = 11'b10111000100;

  logic [4:0]      rd_q   [DEPTH];
  logic [WORD-1:0] data_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic            enq, deq, accept;
  logic [WORD-1:0] sel_data, ext_data;

  assign in_ready = (count_q < CntW'(DEPTH));
  assign idle     = (count_q == '0);
  assign rf_we    = !idle;
  assign rf_waddr = rd_q[head_q];
  assign rf_wdata = data_q[head_q];

  assign accept = in_valid && in_ready;
  // Accepted items that write nothing (or target XZR) are consumed but never queued.
  assign enq    = accept && in_reg_write && (in_rd != 5'd31);
  assign deq    = rf_we && rf_ready;

  always_comb begin
    sel_data = in_mem_to_reg ? in_mem_data : in_alu_result;
    ext_data = sel_data;
    if (in_mem_to_reg) begin
      unique case (in_opcode)
        OpLdurb:  ext_data = {{(WORD-8){1'b0}}, sel_data[7:0]};
        OpLdurh:  ext_data = {{(WORD-16){1'b0}}, sel_data[15:0]};
        OpLdursw: ext_data = {{(WORD-32){sel_data[31]}}, sel_data[31:0]};
        default:  ext_data = sel_data;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins and yields the youngest pending data.
  always_comb begin
    logic [PtrW-1:0] idx;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    idx       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (byp_addr1 != 5'd31 && rd_q[idx] == byp_addr1) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_q[idx];
        end
        if (byp_addr2 != 5'd31 && rd_q[idx] == byp_addr2) begin
          byp_hit2  = 1'b1;
          byp_data2 = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge write_clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        rd_q[tail_q]   <= in_rd;
        data_q[tail_q] <= ext_data;
        tail_q         <= tail_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (!enq && deq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: table-driven single-item vectors, hand-written
// multi-cycle sequences, and a scoreboard that checks every register-file commit in order.
module tb_writeback_unit;

  localparam int unsigned WORD  = 64;
  localparam int unsigned DEPTH = 2;

  localparam logic [10:0] LDURB  = 11'b00111000010;
  localparam logic [10:0] LDURH  = 11'b01111000010;
  localparam logic [10:0] LDURSW = 11'b10111000100;

  logic            write_clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            in_mem_to_reg;
  logic [10:0]     in_opcode;
  logic [WORD-1:0] in_alu_result;
  logic [WORD-1:0] in_mem_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [WORD-1:0] rf_wdata;
  logic            rf_ready;
  logic [4:0]      byp_addr1, byp_addr2;
  logic            byp_hit1, byp_hit2;
  logic [WORD-1:0] byp_data1, byp_data2;
  logic            idle;

  writeback_unit #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .write_clk    (write_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_mem_to_reg(in_mem_to_reg),
    .in_opcode    (in_opcode),
    .in_alu_result(in_alu_result),
    .in_mem_data  (in_mem_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_ready     (rf_ready),
    .byp_addr1    (byp_addr1),
    .byp_addr2    (byp_addr2),
    .byp_hit1     (byp_hit1),
    .byp_hit2     (byp_hit2),
    .byp_data1    (byp_data1),
    .byp_data2    (byp_data2),
    .idle         (idle)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } commit_t;
  commit_t exp_q[$];

  typedef struct {
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic [10:0] opcode;
    logic [63:0] alu;
    logic [63:0] mem;
    logic        exp_write;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [63:0] data);
    commit_t c;
    c.rd   = rd;
    c.data = data;
    exp_q.push_back(c);
  endtask

  // Called at #1 after an edge; presents one item for exactly one edge.
  task automatic push(input logic [4:0] rd, input logic rw, input logic m2r,
                      input logic [10:0] op, input logic [63:0] alu, input logic [63:0] mem);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_opcode     = op;
    in_alu_result = alu;
    in_mem_data   = mem;
    @(posedge write_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  // Scoreboard: a commit happens at the next rising edge whenever this holds at the negedge.
  always @(negedge write_clk) begin
    if (!reset && rf_we && rf_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        commit_t c;
        c = exp_q.pop_front();
        check("commit_rd", 64'(rf_waddr), 64'(c.rd));
        check("commit_data", rf_wdata, c.data);
      end
    end
  end

  initial begin
    vecs[0] = '{5'd5,  1'b1, 1'b0, 11'd0,  64'h1234, 64'h0, 1'b1, 64'h1234};
    vecs[1] = '{5'd7,  1'b1, 1'b1, LDURSW, 64'h0, 64'h0000_0000_8000_0001,
                1'b1, 64'hFFFF_FFFF_8000_0001};
    vecs[2] = '{5'd8,  1'b1, 1'b1, LDURB,  64'h0, 64'hFFFF_FFFF_FFFF_FF7F, 1'b1, 64'h7F};
    vecs[3] = '{5'd9,  1'b1, 1'b1, LDURH,  64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hDEF0};
    vecs[4] = '{5'd10, 1'b1, 1'b0, LDURB,  64'hFFFF_0000_0000_00FF, 64'h1,
                1'b1, 64'hFFFF_0000_0000_00FF};
    vecs[5] = '{5'd11, 1'b1, 1'b1, 11'd0,  64'h5, 64'h0000_0000_0000_CAFE, 1'b1, 64'hCAFE};
    vecs[6] = '{5'd12, 1'b1, 1'b1, LDURSW, 64'h0, 64'h7FFF_FFFF_1234_5678, 1'b1, 64'h1234_5678};
    vecs[7] = '{5'd31, 1'b1, 1'b0, 11'd0,  64'hDEAD, 64'h0, 1'b0, 64'h0};
    vecs[8] = '{5'd3,  1'b0, 1'b0, 11'd0,  64'hBEEF, 64'h0, 1'b0, 64'h0};
    vecs[9] = '{5'd13, 1'b1, 1'b0, LDURH,  64'hAAAA_BBBB_CCCC_DDDD, 64'h1,
                1'b1, 64'hAAAA_BBBB_CCCC_DDDD};

    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
    in_opcode = '0; in_alu_result = '0; in_mem_data = '0; rf_ready = 1'b1;
    byp_addr1 = 5'd0; byp_addr2 = 5'd0;
    step();
    step();
    reset = 1'b0;
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_byp_hit1", 64'(byp_hit1), 64'd0);
    check("reset_byp_data1", byp_data1, 64'd0);

    // Single items with rf_ready high: visible the cycle after accept, gone the next.
    foreach (vecs[i]) begin
      if (vecs[i].exp_write) expect_commit(vecs[i].rd, vecs[i].exp_data);
      push(vecs[i].rd, vecs[i].reg_write, vecs[i].mem_to_reg, vecs[i].opcode,
           vecs[i].alu, vecs[i].mem);
      check($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].exp_write));
      if (vecs[i].exp_write) begin
        check($sformatf("vec%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
        check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
      end
      step();
      check($sformatf("vec%0d_idle_after", i), 64'(idle), 64'd1);
    end

    // Fill to full with the write port stalled, then drain in order.
    rf_ready = 1'b0;
    expect_commit(5'd1, 64'hA);
    expect_commit(5'd2, 64'hB);
    push(5'd1, 1'b1, 1'b0, 11'd0, 64'hA, 64'h0);
    check("full1_in_ready", 64'(in_ready), 64'd1);
    push(5'd2, 1'b1, 1'b0, 11'd0, 64'hB, 64'h0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    push(5'd6, 1'b1, 1'b0, 11'd0, 64'hC, 64'h0);
    check("full_ignored_waddr", 64'(rf_waddr), 64'd1);
    check("full_ignored_hit", 64'(byp_hit1), 64'd0);
    rf_ready = 1'b1;
    check("drain0_wdata", rf_wdata, 64'hA);
    step();
    check("drain1_waddr", 64'(rf_waddr), 64'd2);
    check("drain1_wdata", rf_wdata, 64'hB);
    step();
    check("drain_idle", 64'(idle), 64'd1);

    // Accept and dequeue in the same edge keeps one entry pending.
    rf_ready = 1'b0;
    expect_commit(5'd13, 64'h1);
    expect_commit(5'd14, 64'h2);
    push(5'd13, 1'b1, 1'b0, 11'd0, 64'h1, 64'h0);
    rf_ready = 1'b1;
    push(5'd14, 1'b1, 1'b0, 11'd0, 64'h2, 64'h0);
    check("simul_rf_we", 64'(rf_we), 64'd1);
    check("simul_waddr", 64'(rf_waddr), 64'd14);
    check("simul_in_ready", 64'(in_ready), 64'd1);
    step();
    check("simul_idle", 64'(idle), 64'd1);

    // Bypass: youngest of two same-rd entries wins; XZR never hits.
    rf_ready = 1'b0;
    expect_commit(5'd4, 64'h10);
    expect_commit(5'd4, 64'h20);
    push(5'd4, 1'b1, 1'b0, 11'd0, 64'h10, 64'h0);
    push(5'd4, 1'b1, 1'b0, 11'd0, 64'h20, 64'h0);
    byp_addr1 = 5'd4;
    byp_addr2 = 5'd31;
    #1;
    check("byp_hit1", 64'(byp_hit1), 64'd1);
    check("byp_data1", byp_data1, 64'h20);
    check("byp_hit2_xzr", 64'(byp_hit2), 64'd0);
    check("byp_data2_xzr", byp_data2, 64'd0);
    byp_addr2 = 5'd5;
    #1;
    check("byp_hit2_miss", 64'(byp_hit2), 64'd0);
    rf_ready = 1'b1;
    #1;
    check("byp_hit_while_deq", 64'(byp_hit1), 64'd1);
    step();
    check("byp_data1_after_deq", byp_data1, 64'h20);
    step();
    check("byp_hit1_empty", 64'(byp_hit1), 64'd0);

    // Reset with two pending entries and a concurrent push: all dropped.
    rf_ready = 1'b0;
    push(5'd20, 1'b1, 1'b0, 11'd0, 64'h55, 64'h0);
    push(5'd21, 1'b1, 1'b0, 11'd0, 64'h66, 64'h0);
    check("pre_reset_idle", 64'(idle), 64'd0);
    reset = 1'b1;
    rf_ready = 1'b1;
    byp_addr1 = 5'd20;
    push(5'd22, 1'b1, 1'b0, 11'd0, 64'h77, 64'h0);
    reset = 1'b0;
    check("midreset_rf_we", 64'(rf_we), 64'd0);
    check("midreset_idle", 64'(idle), 64'd1);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_byp_hit1", 64'(byp_hit1), 64'd0);
    check("midreset_byp_data1", byp_data1, 64'd0);
    step();
    step();
    check("post_reset_rf_we", 64'(rf_we), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
